// File: rtl/spi_master_param_if.sv
// Request/response bus between a host controller and spi_master_param.
// The host drives the request side through the master modport; the SPI
// engine receives requests and reports status through the slave modport.
interface spi_master_param_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 8
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic              start_i;
  logic [DATA_W-1:0] tx_data_i;
  logic [CS_W-1:0]   cs_sel_i;
  logic              hold_cs_i;
  logic              stop_i;
  logic              cpol_i;
  logic              cpha_i;
  logic [DIV_W-1:0]  clk_div_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] rx_data_o;

  modport master (
    output start_i, tx_data_i, cs_sel_i, hold_cs_i, stop_i, cpol_i, cpha_i, clk_div_i,
    input  busy_o, done_o, rx_data_o
  );

  modport slave (
    input  start_i, tx_data_i, cs_sel_i, hold_cs_i, stop_i, cpol_i, cpha_i, clk_div_i,
    output busy_o, done_o, rx_data_o
  );
endinterface

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one word per request, all four SPI modes,
// programmable SCK divider and optional chip-select hold for bursts.
//
// state    | meaning
// IDLE     | all selects high, waiting for a request
// SETUP    | select low, SCK at idle level, MOSI shows MSB for one half-period
// SHIFT    | 2*DATA_W SCK edges, one per half-period
// CS_HELD  | word done, select kept low awaiting next word or stop
// TEARDOWN | select kept low one more half-period before release
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_master_param_if.slave bus,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_csb
);
  localparam int EC_W = $clog2(2 * DATA_W + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, CS_HELD, TEARDOWN} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [EC_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d, hold_q, hold_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_CS-1:0] csb_q, csb_d;
  logic              do_edge, leading, sample, cs_valid;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      div_q      <= '0;
      edge_cnt_q <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      hold_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      csb_q      <= '1;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_q      <= div_d;
      edge_cnt_q <= edge_cnt_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      hold_q     <= hold_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      csb_q      <= csb_d;
    end
  end

  // Next-state, half-period timing and SCK edge actions
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    div_d      = div_q;
    edge_cnt_d = edge_cnt_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    hold_d     = hold_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    csb_d      = csb_q;
    done_d     = 1'b0;
    do_edge    = 1'b0;
    leading    = 1'b0;
    sample     = 1'b0;
    cs_valid   = int'(bus.cs_sel_i) < NUM_CS;

    case (state_q)
      IDLE: begin
        if (bus.start_i && cs_valid) begin
          state_d = SETUP;
          for (int i = 0; i < NUM_CS; i++) csb_d[i] = (i != int'(bus.cs_sel_i));
        end
      end
      SETUP, SHIFT: begin
        if (div_cnt_q == '0) begin
          div_cnt_d = div_q;
          do_edge   = 1'b1;
          state_d   = SHIFT;
        end else begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end
      end
      CS_HELD: begin
        // A held word starts in SHIFT with SCK idle for its first
        // half-period so MOSI has a setup time before the leading edge.
        if (bus.start_i) state_d = SHIFT;
        else if (bus.stop_i) begin
          state_d   = TEARDOWN;
          div_cnt_d = div_q;
        end
      end
      TEARDOWN: begin
        if (div_cnt_q == '0) begin
          csb_d   = '1;
          state_d = IDLE;
        end else begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture a new word when leaving IDLE or CS_HELD on a request
    if ((state_q == IDLE && bus.start_i && cs_valid) || (state_q == CS_HELD && bus.start_i)) begin
      cpol_d     = bus.cpol_i;
      cpha_d     = bus.cpha_i;
      hold_d     = bus.hold_cs_i;
      div_d      = bus.clk_div_i;
      div_cnt_d  = bus.clk_div_i;
      edge_cnt_d = EC_W'(2 * DATA_W);
      sck_d      = bus.cpol_i;
      mosi_d     = bus.tx_data_i[DATA_W-1];
      // With CPHA=0 the MSB is already on MOSI, so trailing edges start at bit DATA_W-2.
      tx_sh_d    = bus.cpha_i ? bus.tx_data_i : (bus.tx_data_i << 1);
      rx_sh_d    = '0;
    end

    if (do_edge) begin
      leading    = (sck_q == cpol_q);
      sample     = leading ^ cpha_q;
      sck_d      = ~sck_q;
      edge_cnt_d = edge_cnt_q - EC_W'(1);
      if (sample) rx_sh_d = {rx_sh_q[DATA_W-2:0], spi_miso};
      else begin
        mosi_d  = tx_sh_q[DATA_W-1];
        tx_sh_d = tx_sh_q << 1;
      end
      if (edge_cnt_q == EC_W'(1)) begin
        rx_data_d = rx_sh_d;
        done_d    = 1'b1;
        state_d   = hold_q ? CS_HELD : TEARDOWN;
      end
    end

    busy_d = (state_d != IDLE) && (state_d != CS_HELD);
  end

  assign spi_sck       = sck_q;
  assign spi_mosi      = mosi_q;
  assign spi_csb       = csb_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.rx_data_o = rx_data_q;
endmodule
